// File: rtl/maze_pkg.sv
// Shared definitions for the maze player: FSM state encoding, key bit
// positions, start/exit cell helpers and the score ceiling.
package maze_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_MAZE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_FETCH     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_COMMIT    = 3'd4,
    ST_EXIT      = 3'd5
  } state_e;

  // Bit positions inside the 4-bit direction key vector
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  // Every maze starts the player in cell (1,1)
  localparam logic [7:0] START_X = 8'd1;
  localparam logic [7:0] START_Y = 8'd1;

  // Score display is two decimal digits, so it stops here
  localparam logic [7:0] SCORE_MAX = 8'd99;

  // Exit cell sits on the bottom row, one column in from the right edge
  function automatic logic [7:0] exit_x(input int width);
    return 8'(width - 2);
  endfunction

  function automatic logic [7:0] exit_y(input int height);
    return 8'(height - 1);
  endfunction

  // True when exactly one key is held
  function automatic logic dir_is_onehot(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/maze_if.sv
// Maze memory link: read address out, cell data and maze-valid flag in,
// plus the regeneration request toward the maze generator.
interface maze_if;
  logic        maze_ready;
  logic        maze_data;
  logic [10:0] maze_addr;
  logic        new_maze;

  modport master (input maze_ready, input maze_data, output maze_addr, output new_maze);
  modport slave  (output maze_ready, output maze_data, input maze_addr, input new_maze);
endinterface

// File: rtl/cell_addr_calc.sv
// Linear cell index x + WIDTH*y for the row-major maze memory.
module cell_addr_calc #(
  parameter int WIDTH = 30
) (
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  output logic [10:0] addr_o
);
  assign addr_o = 11'(x_i) + 11'(WIDTH) * 11'(y_i);
endmodule

// File: rtl/player_controller.sv
// Player movement controller: turns key presses into wall-checked moves
// through a fixed-latency maze memory, and handles exit/score/regeneration.
// Optional build macro PLAYER_REPEAT_EN adds held-key auto-repeat.
module player_controller
  import maze_pkg::*;
#(
  parameter int WIDTH         = 30,
  parameter int HEIGHT        = 40,
  parameter int READ_LATENCY  = 2,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] direction,
  input  logic       freeze,
  maze_if.master     mem,
  output logic [7:0] player_x,
  output logic [7:0] player_y,
  output logic       move_done,
  output logic [7:0] mazes_complete
);

  localparam int               WAIT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
  localparam logic [7:0]       LAST_X    = 8'(WIDTH - 1);
  localparam logic [7:0]       LAST_Y    = 8'(HEIGHT - 1);
  localparam logic [7:0]       EXIT_X    = exit_x(WIDTH);
  localparam logic [7:0]       EXIT_Y    = exit_y(HEIGHT);

  // Reject geometries the 8-bit position / 11-bit address cannot express
  if (READ_LATENCY < 1 || REPEAT_CYCLES < 1 || WIDTH > 256 || HEIGHT > 256 ||
      WIDTH * HEIGHT > 2048) begin : g_bad_cfg
    $error("player_controller: unsupported parameter set");
  end

  state_e            state_q, state_d;
  logic [7:0]        px_q, px_d, py_q, py_d;
  logic [7:0]        tx_q, tx_d, ty_q, ty_d;
  logic [3:0]        dir_prev_q;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              data_q, data_d;
  logic [7:0]        score_q, score_d;
  logic              sel_target, done_pulse, exit_pulse;
  logic [7:0]        cand_x, cand_y;
  logic              cand_ok, new_press, repeat_fire, request;
  logic [7:0]        addr_x, addr_y;
  logic [10:0]       cell_addr;

  assign new_press = dir_is_onehot(direction) && (direction != dir_prev_q);

`ifdef PLAYER_REPEAT_EN
  localparam int              REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_q;
  logic             held;

  assign held        = dir_is_onehot(direction) && (direction == dir_prev_q);
  assign repeat_fire = held && (rep_cnt_q == REP_LAST);

  // Count cycles a single key stays held; restart on release, change or fire
  always_ff @(posedge clock) begin
    if (reset || !held || repeat_fire) rep_cnt_q <= '0;
    else                               rep_cnt_q <= rep_cnt_q + 1'b1;
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign request = (new_press || repeat_fire) && !freeze;

  // Neighbour cell in the pressed direction, flagged invalid at the maze edge
  always_comb begin
    cand_x  = px_q;
    cand_y  = py_q;
    cand_ok = 1'b0;
    if (direction[DIR_UP]) begin
      cand_y  = py_q - 8'd1;
      cand_ok = (py_q != 8'd0);
    end else if (direction[DIR_DOWN]) begin
      cand_y  = py_q + 8'd1;
      cand_ok = (py_q != LAST_Y);
    end else if (direction[DIR_LEFT]) begin
      cand_x  = px_q - 8'd1;
      cand_ok = (px_q != 8'd0);
    end else if (direction[DIR_RIGHT]) begin
      cand_x  = px_q + 8'd1;
      cand_ok = (px_q != LAST_X);
    end
  end

  // Next-state and pulse decode; losing the maze always wins over everything
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    wait_cnt_d = wait_cnt_q;
    data_d     = data_q;
    score_d    = score_q;
    sel_target = 1'b0;
    done_pulse = 1'b0;
    exit_pulse = 1'b0;
    unique case (state_q)
      ST_WAIT_MAZE: if (mem.maze_ready) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!mem.maze_ready) state_d = ST_WAIT_MAZE;
        else if (request && cand_ok) begin
          tx_d    = cand_x;
          ty_d    = cand_y;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        sel_target = 1'b1;
        if (!mem.maze_ready) state_d = ST_WAIT_MAZE;
        else if (freeze)     state_d = ST_IDLE;
        else begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        sel_target = 1'b1;
        if (!mem.maze_ready) state_d = ST_WAIT_MAZE;
        else if (freeze)     state_d = ST_IDLE;
        else if (wait_cnt_q == WAIT_LAST) begin
          data_d  = mem.maze_data;
          state_d = ST_COMMIT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        sel_target = 1'b1;
        if (!mem.maze_ready) state_d = ST_WAIT_MAZE;
        else if (data_q) begin
          done_pulse = 1'b1;
          px_d       = tx_q;
          py_d       = ty_q;
          state_d    = (tx_q == EXIT_X && ty_q == EXIT_Y) ? ST_EXIT : ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXIT: begin
        exit_pulse = 1'b1;
        px_d       = START_X;
        py_d       = START_Y;
        score_d    = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 8'd1;
        state_d    = ST_WAIT_MAZE;
      end
      default: state_d = ST_WAIT_MAZE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight move
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_WAIT_MAZE;
      px_q       <= START_X;
      py_q       <= START_Y;
      tx_q       <= START_X;
      ty_q       <= START_Y;
      dir_prev_q <= '0;
      wait_cnt_q <= '0;
      data_q     <= 1'b0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      dir_prev_q <= direction;
      wait_cnt_q <= wait_cnt_d;
      data_q     <= data_d;
      score_q    <= score_d;
    end
  end

  // Memory sees the target while a lookup is in flight, otherwise the player cell
  assign addr_x = sel_target ? tx_q : px_q;
  assign addr_y = sel_target ? ty_q : py_q;

  cell_addr_calc #(.WIDTH(WIDTH)) u_addr (
    .x_i   (addr_x),
    .y_i   (addr_y),
    .addr_o(cell_addr)
  );

  assign mem.maze_addr  = cell_addr;
  assign mem.new_maze   = exit_pulse & ~reset;
  assign move_done      = done_pulse & ~reset;
  assign player_x       = px_q;
  assign player_y       = py_q;
  assign mazes_complete = score_q;

endmodule

// File: tb/tb_player_controller.sv
// Self-checking bench for player_controller: directed corner cases, a
// randomized press sequence and a score-saturation run, all scored against
// a transaction-level model of the player position and score.
module tb_player_controller;

  localparam int W   = 7;
  localparam int H   = 5;
  localparam int RL  = 2;
  localparam int WIN = RL + 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] direction;
  logic       freeze;
  logic [7:0] player_x, player_y, mazes_complete;
  logic       move_done;

  maze_if mif ();

  player_controller #(
    .WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL), .REPEAT_CYCLES(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .direction     (direction),
    .freeze        (freeze),
    .mem           (mif),
    .player_x      (player_x),
    .player_y      (player_y),
    .move_done     (move_done),
    .mazes_complete(mazes_complete)
  );

  always #5 clock = ~clock;

  // Maze memory model: contents array behind an RL-deep address pipeline
  logic        mem_open [W*H];
  logic [10:0] addr_pipe [RL];

  always @(posedge clock) begin
    addr_pipe[0] <= mif.maze_addr;
    for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  always_comb begin
    mif.maze_data = 1'b0;
    if (int'(addr_pipe[RL-1]) < W*H) mif.maze_data = mem_open[addr_pipe[RL-1]];
  end

  int total = 0;
  int bad   = 0;
  int mx, my, mscore, exits_seen, open_pct;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_maze(input int pct);
    for (int i = 0; i < W*H; i++) mem_open[i] = ($urandom_range(99) < pct);
  endtask

  // One key press from IDLE. mode: 0 plain, 1 freeze in WAIT, 2 maze_ready
  // drop in WAIT, 3 freeze on the press cycle, 4 reset in WAIT.
  task automatic press(input logic [3:0] pat, input int mode);
    int tx, ty, cur_addr, md_first, md_cnt, nm_first, nm_cnt;
    bit accepted, fetch, commit, is_exit;
    tx = mx; ty = my;
    if (pat[0])      ty = my - 1;
    else if (pat[1]) ty = my + 1;
    else if (pat[2]) tx = mx - 1;
    else if (pat[3]) tx = mx + 1;
    accepted = ($countones(pat) == 1) && (mode != 3);
    fetch    = accepted && tx >= 0 && tx < W && ty >= 0 && ty < H;
    commit   = 1'b0;
    if (fetch && mode == 0) commit = mem_open[tx + W*ty];
    is_exit  = commit && tx == W-2 && ty == H-1;
    cur_addr = mx + W*my;
    md_first = 0; md_cnt = 0; nm_first = 0; nm_cnt = 0;

    direction = pat;
    freeze    = (mode == 3);
    tick();
    for (int k = 1; k <= WIN; k++) begin
      if (move_done) begin md_cnt++; if (md_first == 0) md_first = k; end
      if (mif.new_maze) begin nm_cnt++; if (nm_first == 0) nm_first = k; end
      if (k == 1) freeze = 1'b0;
      if (k == 2) begin
        check("wait_addr", int'(mif.maze_addr), fetch ? tx + W*ty : cur_addr);
        if (fetch) begin
          if (mode == 1) freeze = 1'b1;
          if (mode == 2) mif.maze_ready = 1'b0;
          if (mode == 4) reset = 1'b1;
        end
      end
      if (k == 3) begin
        freeze = 1'b0;
        mif.maze_ready = 1'b1;
        reset = 1'b0;
      end
      tick();
    end
    direction = 4'd0;
    tick();

    if (mode == 4 && fetch) begin
      mx = 1; my = 1; mscore = 0;
    end else if (is_exit) begin
      mx = 1; my = 1;
      mscore = (mscore >= 99) ? 99 : mscore + 1;
      exits_seen++;
    end else if (commit) begin
      mx = tx; my = ty;
    end

    $display("press pat=%b mode=%0d -> pos=(%0d,%0d) score=%0d done=%0d@%0d new=%0d",
             pat, mode, player_x, player_y, mazes_complete, md_cnt, md_first, nm_cnt);
    check("done_count", md_cnt, commit ? 1 : 0);
    check("done_cycle", md_first, commit ? RL + 2 : 0);
    check("newmaze_count", nm_cnt, is_exit ? 1 : 0);
    check("newmaze_cycle", nm_first, is_exit ? RL + 3 : 0);
    check("pos_x", int'(player_x), mx);
    check("pos_y", int'(player_y), my);
    check("score", int'(mazes_complete), mscore);
    check("idle_addr", int'(mif.maze_addr), mx + W*my);
    if (is_exit) fill_maze(open_pct);
  endtask

  // With maze_ready low, a fresh press must not move the player
  task automatic probe_not_ready();
    int pulses;
    pulses = 0;
    mif.maze_ready = 1'b0;
    tick();
    direction = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      if (move_done) pulses++;
      tick();
    end
    check("nr_addr", int'(mif.maze_addr), mx + W*my);
    direction = 4'd0;
    tick();
    $display("not-ready probe -> pos=(%0d,%0d) pulses=%0d", player_x, player_y, pulses);
    check("nr_moves", pulses, 0);
    check("nr_pos_x", int'(player_x), mx);
    mif.maze_ready = 1'b1;
    tick();
    tick();
  endtask

  // Walk an all-open maze to the exit cell until one exit is taken
  task automatic walk_to_exit();
    int n;
    n = exits_seen;
    while (exits_seen == n) begin
      if (mx < W-2)      press(4'b1000, 0);
      else if (mx > W-2) press(4'b0100, 0);
      else               press(4'b0010, 0);
    end
  endtask

  initial begin
    logic [3:0] one;
    int r, mode;
    logic [3:0] pat;
    one = 4'b0001;
    reset = 1'b1; freeze = 1'b0; direction = 4'd0;
    mif.maze_ready = 1'b0;
    open_pct = 100;
    fill_maze(100);
    mx = 1; my = 1; mscore = 0; exits_seen = 0;
    tick();
    tick();
    $display("reset -> pos=(%0d,%0d) score=%0d addr=%0d", player_x, player_y, mazes_complete, mif.maze_addr);
    check("rst_x", int'(player_x), 1);
    check("rst_y", int'(player_y), 1);
    check("rst_score", int'(mazes_complete), 0);
    check("rst_done", int'(move_done), 0);
    check("rst_new", int'(mif.new_maze), 0);
    check("rst_addr", int'(mif.maze_addr), 1 + W);
    reset = 1'b0;
    tick();

    probe_not_ready();

    // Directed cases on an all-open maze
    press(4'b0010, 0);                 // down to (1,2)
    press(4'b0001, 0);                 // back up to (1,1)
    mem_open[2 + W*1] = 1'b0;
    press(4'b1000, 0);                 // wall at (2,1)
    mem_open[2 + W*1] = 1'b1;
    press(4'b0100, 0);                 // to (0,1)
    press(4'b0100, 0);                 // off the left edge: dropped
    press(4'b1000, 1);                 // freeze during WAIT
    press(4'b0011, 0);                 // two keys: ignored
    press(4'b0000, 0);                 // no key
    press(4'b1000, 3);                 // frozen at press time
    press(4'b0001, 2);                 // maze lost during WAIT
    press(4'b0001, 0);                 // to (0,0)
    press(4'b0001, 0);                 // off the top edge: dropped
    press(4'b1000, 4);                 // reset during WAIT

    // Randomized presses on random mazes
    open_pct = 70;
    fill_maze(open_pct);
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(99));
      mode = (r < 80) ? 0 : (r < 86) ? 1 : (r < 92) ? 2 : (r < 98) ? 3 : 4;
      if ($urandom_range(9) < 8) pat = one << $urandom_range(3);
      else                       pat = 4'($urandom_range(15));
      press(pat, mode);
    end

    // Score saturation: enough exits to reach 99 and go past it
    open_pct = 100;
    fill_maze(100);
    walk_to_exit();
    probe_not_ready();
    for (int e = 0; e < 100; e++) walk_to_exit();
    check("score_sat", int'(mazes_complete), 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
